// File: rtl/ll8_to_txmac_gap.sv
// LocalLink (8-bit) to TX MAC byte bridge with first-byte ack hold, abort handling and inter-frame gap.
// Optional abort counter enabled by defining LL8_TXMAC_ABORT_CNT_EN.
module ll8_to_txmac_gap #(
    parameter int IFG_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [7:0]  ll_data,
    input  logic        ll_sof,
    input  logic        ll_eof,
    input  logic        ll_error,
    input  logic        ll_src_rdy,
    output logic        ll_dst_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_error,
    input  logic        tx_ack,
    output logic        tx_busy,
    output logic [15:0] abort_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP, GAP} state_t;

    // With a zero gap, every frame end goes straight back to IDLE.
    localparam state_t     END_STATE = (IFG_CYCLES == 0) ? IDLE : GAP;
    localparam logic [7:0] GAP_LOAD  = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] gap_cnt;
    logic       abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gap_cnt <= 8'd0;
        end else if (clear) begin
            state   <= IDLE;
            gap_cnt <= 8'd0;
        end else begin
            state <= next_state;
            if (next_state == GAP && state != GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == GAP && gap_cnt != 8'd0)
                gap_cnt <= gap_cnt - 8'd1;
        end
    end

    always_comb begin
        next_state = state;
        ll_dst_rdy = 1'b0;
        tx_valid   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (ll_src_rdy && !ll_sof) begin
                    ll_dst_rdy = 1'b1;
                end else if (ll_src_rdy && ll_sof) begin
                    tx_valid   = 1'b1;
                    ll_dst_rdy = tx_ack;
                    if (tx_ack) begin
                        abort = ll_error;
                        if (ll_eof)
                            next_state = END_STATE;
                        else if (ll_error)
                            next_state = DROP;
                        else
                            next_state = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                tx_valid = 1'b1;
                if (!ll_src_rdy) begin
                    abort      = 1'b1;
                    next_state = DROP;
                end else if (ll_sof) begin
                    // The sof byte belongs to the next frame, so it is left in place.
                    abort      = 1'b1;
                    next_state = END_STATE;
                end else if (ll_error) begin
                    abort      = 1'b1;
                    ll_dst_rdy = 1'b1;
                    next_state = ll_eof ? END_STATE : DROP;
                end else begin
                    ll_dst_rdy = 1'b1;
                    if (ll_eof)
                        next_state = END_STATE;
                end
            end
            DROP: begin
                if (ll_src_rdy && ll_sof) begin
                    next_state = END_STATE;
                end else begin
                    ll_dst_rdy = 1'b1;
                    if (ll_src_rdy && ll_eof)
                        next_state = END_STATE;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign tx_error = abort;
    assign tx_data  = ll_data;
    assign tx_busy  = (state != IDLE);

`ifdef LL8_TXMAC_ABORT_CNT_EN
    logic [15:0] abort_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            abort_q <= 16'h0000;
        else if (clear)
            abort_q <= 16'h0000;
        else if (abort && abort_q != 16'hFFFF)
            abort_q <= abort_q + 16'd1;
    end

    assign abort_count = abort_q;
`else
    assign abort_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ll8_to_txmac_gap.sv
// Directed bench for ll8_to_txmac_gap: default IFG_CYCLES=2 instance plus an IFG_CYCLES=0 instance.
module tb_ll8_to_txmac_gap;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [7:0]  ll_data;
    logic        ll_sof, ll_eof, ll_error, ll_src_rdy, tx_ack;
    logic        ll_dst_rdy, tx_valid, tx_error, tx_busy;
    logic [7:0]  tx_data;
    logic [15:0] abort_count;

    logic [7:0]  z_data;
    logic        z_sof, z_eof, z_error, z_src_rdy, z_ack;
    logic        z_dst_rdy, z_valid, z_txerr, z_busy;
    logic [7:0]  z_txdata;
    logic [15:0] z_abort_count;

    int tests_run = 0;
    int tests_failed = 0;

    ll8_to_txmac_gap dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .ll_data(ll_data), .ll_sof(ll_sof), .ll_eof(ll_eof), .ll_error(ll_error),
        .ll_src_rdy(ll_src_rdy), .ll_dst_rdy(ll_dst_rdy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_error(tx_error), .tx_ack(tx_ack),
        .tx_busy(tx_busy), .abort_count(abort_count)
    );

    ll8_to_txmac_gap #(.IFG_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .ll_data(z_data), .ll_sof(z_sof), .ll_eof(z_eof), .ll_error(z_error),
        .ll_src_rdy(z_src_rdy), .ll_dst_rdy(z_dst_rdy),
        .tx_data(z_txdata), .tx_valid(z_valid), .tx_error(z_txerr), .tx_ack(z_ack),
        .tx_busy(z_busy), .abort_count(z_abort_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_aborts(input int n);
`ifdef LL8_TXMAC_ABORT_CNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the main instance, check combinational outputs, then advance.
    task automatic cyc(input string tag, input logic src, input logic sof, input logic eof,
                       input logic err, input logic [7:0] d, input logic ack,
                       input logic e_dst, input logic e_val, input logic e_err, input logic e_busy);
        ll_src_rdy = src; ll_sof = sof; ll_eof = eof; ll_error = err; ll_data = d; tx_ack = ack;
        #2;
        check({tag, ".dst_rdy"}, 32'(ll_dst_rdy), 32'(e_dst));
        check({tag, ".valid"},   32'(tx_valid),   32'(e_val));
        check({tag, ".error"},   32'(tx_error),   32'(e_err));
        check({tag, ".busy"},    32'(tx_busy),    32'(e_busy));
        if (e_val) check({tag, ".data"}, 32'(tx_data), 32'(d));
        tick();
    endtask

    task automatic cyc0(input string tag, input logic src, input logic sof, input logic eof,
                        input logic [7:0] d, input logic ack,
                        input logic e_dst, input logic e_val, input logic e_busy);
        z_src_rdy = src; z_sof = sof; z_eof = eof; z_error = 1'b0; z_data = d; z_ack = ack;
        #2;
        check({tag, ".dst_rdy"}, 32'(z_dst_rdy), 32'(e_dst));
        check({tag, ".valid"},   32'(z_valid),   32'(e_val));
        check({tag, ".error"},   32'(z_txerr),   32'(0));
        check({tag, ".busy"},    32'(z_busy),    32'(e_busy));
        tick();
    endtask

    task automatic idle_gap(input string tag);
        cyc({tag, ".gap1"}, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1);
        cyc({tag, ".gap2"}, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1);
        cyc({tag, ".idle"}, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0;
        ll_data = '0; ll_sof = 0; ll_eof = 0; ll_error = 0; ll_src_rdy = 0; tx_ack = 0;
        z_data = '0; z_sof = 0; z_eof = 0; z_error = 0; z_src_rdy = 0; z_ack = 0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // reset state
        check("rst.busy", 32'(tx_busy), 32'(0));
        check("rst.dst_rdy", 32'(ll_dst_rdy), 32'(0));
        check("rst.valid", 32'(tx_valid), 32'(0));
        check("rst.error", 32'(tx_error), 32'(0));
        check("rst.aborts", 32'(abort_count), 32'(0));

        // 1: 5-byte frame, ack on the third sof cycle
        cyc("t1.sof_w1", 1, 1, 0, 0, 8'h11, 0, 0, 1, 0, 0);
        cyc("t1.sof_w2", 1, 1, 0, 0, 8'h11, 0, 0, 1, 0, 0);
        cyc("t1.sof_ack", 1, 1, 0, 0, 8'h11, 1, 1, 1, 0, 0);
        cyc("t1.b2", 1, 0, 0, 0, 8'h12, 0, 1, 1, 0, 1);
        cyc("t1.b3", 1, 0, 0, 0, 8'h13, 0, 1, 1, 0, 1);
        cyc("t1.b4", 1, 0, 0, 0, 8'h14, 0, 1, 1, 0, 1);
        cyc("t1.eof", 1, 0, 1, 0, 8'h15, 0, 1, 1, 0, 1);
        idle_gap("t1");

        // 2: single-byte frame
        cyc("t2.one", 1, 1, 1, 0, 8'hA5, 1, 1, 1, 0, 0);
        idle_gap("t2");

        // 3: underrun after the third byte, rest drained
        cyc("t3.b1", 1, 1, 0, 0, 8'h21, 1, 1, 1, 0, 0);
        cyc("t3.b2", 1, 0, 0, 0, 8'h22, 0, 1, 1, 0, 1);
        cyc("t3.b3", 1, 0, 0, 0, 8'h23, 0, 1, 1, 0, 1);
        cyc("t3.under", 0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 1);
        check("t3.aborts", 32'(abort_count), 32'(exp_aborts(1)));
        cyc("t3.d4", 1, 0, 0, 0, 8'h24, 0, 1, 0, 0, 1);
        cyc("t3.d5", 1, 0, 0, 0, 8'h25, 0, 1, 0, 0, 1);
        cyc("t3.d6", 1, 0, 1, 0, 8'h26, 0, 1, 0, 0, 1);
        idle_gap("t3");

        // 4: missing eof; the new sof waits out the gap and is sent next
        cyc("t4.b1", 1, 1, 0, 0, 8'h31, 1, 1, 1, 0, 0);
        cyc("t4.b2", 1, 0, 0, 0, 8'h32, 0, 1, 1, 0, 1);
        cyc("t4.nosof", 1, 1, 1, 0, 8'h41, 0, 0, 1, 1, 1);
        cyc("t4.gap1", 1, 1, 1, 0, 8'h41, 0, 0, 0, 0, 1);
        cyc("t4.gap2", 1, 1, 1, 0, 8'h41, 0, 0, 0, 0, 1);
        cyc("t4.next", 1, 1, 1, 0, 8'h41, 1, 1, 1, 0, 0);
        check("t4.aborts", 32'(abort_count), 32'(exp_aborts(2)));
        idle_gap("t4");

        // 5: stray byte, then upstream error on byte 2
        cyc("t5.stray", 1, 0, 0, 0, 8'h55, 0, 1, 0, 0, 0);
        cyc("t5.b1", 1, 1, 0, 0, 8'h61, 1, 1, 1, 0, 0);
        cyc("t5.err", 1, 0, 0, 1, 8'h62, 0, 1, 1, 1, 1);
        cyc("t5.d3", 1, 0, 0, 0, 8'h63, 0, 1, 0, 0, 1);
        cyc("t5.d4", 1, 0, 1, 0, 8'h64, 0, 1, 0, 0, 1);
        check("t5.aborts", 32'(abort_count), 32'(exp_aborts(3)));
        idle_gap("t5");

        // 6a: async reset mid-ACTIVE
        cyc("t6.b1", 1, 1, 0, 0, 8'h71, 1, 1, 1, 0, 0);
        cyc("t6.b2", 1, 0, 0, 0, 8'h72, 0, 1, 1, 0, 1);
        ll_data = 8'h73;
        reset_n = 1'b0;
        #2;
        check("t6.rst.busy", 32'(tx_busy), 32'(0));
        check("t6.rst.valid", 32'(tx_valid), 32'(0));
        check("t6.rst.error", 32'(tx_error), 32'(0));
        check("t6.rst.aborts", 32'(abort_count), 32'(0));
        tick();
        reset_n = 1'b1;
        cyc("t6.post", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);

        // 6b: errored single-byte frame, then clear during GAP
        cyc("t6.errone", 1, 1, 1, 1, 8'h81, 1, 1, 1, 1, 0);
        check("t6.aborts1", 32'(abort_count), 32'(exp_aborts(1)));
        clear = 1'b1;
        cyc("t6.clr", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1);
        clear = 1'b0;
        check("t6.clr.aborts", 32'(abort_count), 32'(0));
        cyc("t6.clr.idle", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);

        // 6c: IFG_CYCLES=0 instance returns to IDLE right after eof
        cyc0("z.one", 1, 1, 1, 8'h91, 1, 1, 1, 0);
        cyc0("z.b1", 1, 1, 0, 8'h92, 1, 1, 1, 0);
        cyc0("z.eof", 1, 0, 1, 8'h93, 0, 1, 1, 1);
        cyc0("z.idle", 0, 0, 0, 8'h00, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
